// File: rtl/melbank_pkg.sv
// Shared types and constants for the mel filterbank coefficient loader.
// Holds the controller state encoding plus table depth and checksum width.
package melbank_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 9;
  localparam int DEPTH              = 2 ** DEFAULT_ADDR_WIDTH;
  localparam int CKSUM_WIDTH        = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/melbank_cksum.sv
// Modulo-2^16 running sum with synchronous clear (priority) and enable.
// Data wider than the accumulator is truncated; narrower data is zero-extended.
module melbank_cksum
  import melbank_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                   clk_tb,
  input  logic                   tb_rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [CKSUM_WIDTH-1:0] sum
);

  logic [CKSUM_WIDTH-1:0] sum_q;
  logic [CKSUM_WIDTH-1:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (en) begin
      sum_d = sum_q + CKSUM_WIDTH'(din);
    end
  end

  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/melbank_coef_loader.sv
// Streams coefficients into a table, reads the whole table back, and checks the
// readback sum against the load checksum. Stream: a beat moves when s_valid & s_ready.
module melbank_coef_loader
  import melbank_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic                   clk_tb,
  input  logic                   tb_rst,
  input  logic                   start,
  input  logic                   s_valid,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic                   s_ready,
  output logic                   ram_we,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic [DATA_WIDTH-1:0]  ram_wdata,
  input  logic [DATA_WIDTH-1:0]  ram_rdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [CKSUM_WIDTH-1:0] checksum
);

  state_e                 state_q;
  state_e                 state_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   err_q;
  logic                   rd_vld_q;
  logic                   launch;
  logic                   beat;
  logic                   last_addr;
  logic                   sum_match;
  logic [CKSUM_WIDTH-1:0] load_sum;
  logic [CKSUM_WIDTH-1:0] verify_sum;

  // Only IDLE listens to start, so a start while busy falls on deaf ears.
  assign launch    = (state_q == ST_IDLE) && start;
  assign beat      = (state_q == ST_LOAD) && s_valid;
  assign last_addr = &addr_q;
  assign sum_match = (verify_sum == load_sum);

  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_LOAD;
      ST_LOAD:   if (beat && last_addr) state_d = ST_VERIFY;
      ST_VERIFY: if (last_addr) state_d = ST_FLUSH;
      ST_FLUSH:  state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = err_q;
    unique case (state_q)
      ST_LOAD: begin
        s_ready  = 1'b1;
        busy     = 1'b1;
        ram_addr = addr_q;
        if (s_valid) begin
          ram_we    = 1'b1;
          ram_wdata = s_data;
        end
      end
      ST_VERIFY: begin
        busy     = 1'b1;
        ram_addr = addr_q;
      end
      // Both sums are final here: the last readback was absorbed during FLUSH.
      ST_DONE: begin
        done = sum_match && !err_q;
        err  = err_q || !sum_match;
      end
      default: begin
        s_ready = 1'b0;
      end
    endcase
  end

  // One counter serves both passes; it wraps to 0 at the end of each.
  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      addr_q <= '0;
    end else if (launch) begin
      addr_q <= '0;
    end else if (beat || (state_q == ST_VERIFY)) begin
      addr_q <= addr_q + ADDR_WIDTH'(1);
    end
  end

  // Read data trails its address by one cycle.
  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= (state_q == ST_VERIFY);
    end
  end

  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      err_q <= 1'b0;
    end else if (launch) begin
      err_q <= 1'b0;
    end else if ((state_q == ST_DONE) && !sum_match) begin
      err_q <= 1'b1;
    end
  end

  melbank_cksum #(.DATA_WIDTH(DATA_WIDTH)) u_load_sum (
    .clk_tb (clk_tb),
    .tb_rst (tb_rst),
    .clr    (launch),
    .en     (beat),
    .din    (s_data),
    .sum    (load_sum)
  );

  melbank_cksum #(.DATA_WIDTH(DATA_WIDTH)) u_verify_sum (
    .clk_tb (clk_tb),
    .tb_rst (tb_rst),
    .clr    (launch),
    .en     (rd_vld_q),
    .din    (ram_rdata),
    .sum    (verify_sum)
  );

  assign checksum = load_sum;

endmodule

// File: tb/tb_melbank_coef_loader.sv
// Directed bench for melbank_coef_loader: table of load scenarios plus
// hand-written reset-mid-load sequence, with a synchronous-read RAM model.
module tb_melbank_coef_loader;

  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam int DEPTH = 2 ** AW;

  // clock / reset
  logic clk_tb = 1'b0;
  logic tb_rst;
  always #5 clk_tb = ~clk_tb;

  logic          start;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   checksum;

  melbank_coef_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_tb    (clk_tb),
    .tb_rst    (tb_rst),
    .start     (start),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .checksum  (checksum)
  );

  // RAM model: one-cycle read latency, optional +1 corruption at address 0x17
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;
  logic [AW-1:0] raddr_q;
  logic          corrupt;

  always @(posedge clk_tb) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rdata_q <= mem[ram_addr];
    raddr_q <= ram_addr;
  end
  assign ram_rdata = (corrupt && raddr_q == 9'h017) ? rdata_q + 8'd1 : rdata_q;

  // scoreboard
  int n_chk  = 0;
  int n_fail = 0;
  logic [AW+DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dval(input bit all_ff, input int idx);
    logic [31:0] v;
    v = idx;
    return all_ff ? 8'hFF : v[7:0];
  endfunction

  typedef struct {
    bit          toggle;
    bit          all_ff;
    bit          corrupt;
    int          mid_start;
    logic [15:0] exp_cksum;
    bit          exp_err;
    int          exp_done_cyc;
    int          exp_load_cyc;
  } vec_t;

  vec_t vecs[5];

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"},   32'(s_ready),   32'd0);
    check({tag, "_ram_we"},    32'(ram_we),    32'd0);
    check({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
    check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_err"},       32'(err),       32'd0);
    check({tag, "_checksum"},  32'(checksum),  32'd0);
  endtask

  // driver: one full start..IDLE operation; cycle 1 is the first LOAD cycle
  task automatic run_vec(input vec_t v, input int id);
    int total;
    int beat;
    int load_cyc;
    int v_idx;
    int done_cnt;
    int done_at;
    logic [AW+DW-1:0] e;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({AW'(i), dval(v.all_ff, i)});
    corrupt  = v.corrupt;
    total    = (v.toggle ? 1023 : 512) + 520;
    beat     = 0;
    load_cyc = 0;
    v_idx    = 0;
    done_cnt = 0;
    done_at  = -1;

    @(negedge clk_tb);
    start   = 1'b1;
    s_valid = 1'b1;
    s_data  = dval(v.all_ff, 0);
    #1;
    check($sformatf("v%0d_idle_ready", id), 32'(s_ready), 32'd0);
    check($sformatf("v%0d_idle_no_write", id), 32'(ram_we), 32'd0);

    for (int cyc = 1; cyc <= total; cyc++) begin
      @(negedge clk_tb);
      start   = (cyc == v.mid_start);
      s_valid = v.toggle ? (cyc % 2 == 1) : 1'b1;
      s_data  = dval(v.all_ff, beat);
      #1;
      if (cyc == 1) check($sformatf("v%0d_err_cleared", id), 32'(err), 32'd0);
      if (s_ready) load_cyc++;
      if (ram_we) begin
        if (exp_q.size() == 0) begin
          check($sformatf("v%0d_extra_write", id), 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("v%0d_write", id), 32'({ram_addr, ram_wdata}), 32'(e));
        end
      end
      if (s_valid && s_ready) beat++;
      if (busy && !s_ready) begin
        check($sformatf("v%0d_verify_addr", id), 32'(ram_addr), 32'(v_idx));
        check($sformatf("v%0d_verify_we", id), 32'(ram_we), 32'd0);
        v_idx++;
      end
      if (done) begin
        done_cnt++;
        done_at = cyc;
      end
    end
    start   = 1'b0;
    s_valid = 1'b0;
    #1;
    check($sformatf("v%0d_writes_left", id), 32'(exp_q.size()), 32'd0);
    check($sformatf("v%0d_load_cycles", id), 32'(load_cyc), 32'(v.exp_load_cyc));
    check($sformatf("v%0d_verify_count", id), 32'(v_idx), 32'(DEPTH));
    check($sformatf("v%0d_done_count", id), 32'(done_cnt), v.exp_err ? 32'd0 : 32'd1);
    check($sformatf("v%0d_done_cycle", id), 32'(done_at), v.exp_err ? 32'hFFFF_FFFF : 32'(v.exp_done_cyc));
    check($sformatf("v%0d_err", id), 32'(err), 32'(v.exp_err));
    check($sformatf("v%0d_checksum", id), 32'(checksum), 32'(v.exp_cksum));
    check($sformatf("v%0d_idle_busy", id), 32'(busy), 32'd0);
  endtask

  initial begin
    // toggle, all_ff, corrupt, mid_start, cksum, err, done cycle, LOAD cycles
    vecs[0] = '{0, 0, 0, -1,  16'hFF00, 0, 1026, 512};
    vecs[1] = '{1, 0, 0, -1,  16'hFF00, 0, 1537, 1023};
    vecs[2] = '{0, 0, 1, -1,  16'hFF00, 1, 1026, 512};
    // 512 * 0xFF = 0x1FE00, which wraps to 0xFE00
    vecs[3] = '{0, 1, 0, -1,  16'hFE00, 0, 1026, 512};
    vecs[4] = '{0, 0, 0, 700, 16'hFF00, 0, 1026, 512};

    tb_rst  = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    corrupt = 1'b0;
    repeat (3) @(negedge clk_tb);
    check_reset_values("reset");
    tb_rst = 1'b0;

    // reset in the middle of LOAD, at address 100
    begin
      int  beat;
      bit  hit;
      int  spurious;
      beat = 0;
      hit  = 1'b0;
      @(negedge clk_tb);
      start   = 1'b1;
      s_valid = 1'b0;
      for (int cyc = 1; cyc <= 200 && !hit; cyc++) begin
        @(negedge clk_tb);
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = dval(1'b0, beat);
        #1;
        if (ram_we && ram_addr == 9'd100) hit = 1'b1;
        else if (s_ready) beat++;
      end
      check("rst_mid_reached_addr100", 32'(hit), 32'd1);
      check("rst_mid_cksum_before", 32'(checksum), 32'd4950);
      tb_rst = 1'b1;
      #1;
      check_reset_values("rst_mid");
      @(negedge clk_tb);
      tb_rst   = 1'b0;
      spurious = 0;
      for (int cyc = 0; cyc < 1100; cyc++) begin
        @(negedge clk_tb);
        #1;
        if (done || busy || ram_we) spurious++;
      end
      check("rst_mid_no_activity", 32'(spurious), 32'd0);
      s_valid = 1'b0;
    end

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
